config_register_bank: RTL and testbench
=======================================

// Module: config_register_bank
// PURPOSE
//  Consumes decoded (address, data, valid) writes from address_decoder and acknowledges each one.
//  Holds the VGA configuration registers as a shadow copy and an active copy.
//  Shadow->active copy happens only at a frame boundary or on an explicit command, so the display
//  never changes mid-frame. Sits between address_decoder and the VGA timing/pixel logic.
// PARAMETERS
//  DATA_W    4          width of each register and of the data input
//  ADDR_W    4          width of the address input
//  NUM_REGS  8          implemented registers, addresses 0..NUM_REGS-1 (NUM_REGS <= 2**ADDR_W-1)
//  CMD_ADDR  4'hF       command address; the data value selects the action
//  RST_VALS  32'h0000_0000  per-register default values, packed; reg i = RST_VALS[i*DATA_W +: DATA_W]
// PORTS
//  clk          in   1                  system clock
//  rst          in   1                  async active-high reset
//  valid        in   1                  write request from address_decoder; level, held until ack
//  address      in   ADDR_W             register address, stable while valid=1
//  data         in   DATA_W             write data, stable while valid=1
//  frame_start  in   1                  one-cycle pulse at start of vertical blanking
//  ack          out  1                  one-cycle pulse when the write is accepted
//  cfg_active   out  NUM_REGS*DATA_W    active registers, packed (reg i at [i*DATA_W +: DATA_W])
//  dirty        out  1                  shadow differs from active (pending commit)
//  addr_err     out  1                  sticky: write to an unimplemented, non-command address
// BEHAVIOUR
//  Reset (async): shadow = active = RST_VALS; ack=0, dirty=0, addr_err=0; FSM=IDLE.
//  FSM states and transitions:
//   IDLE: if valid=1 -> CAPTURE.
//   CAPTURE: register the address and data (one cycle) -> APPLY.
//   APPLY:
//    addr < NUM_REGS: shadow[addr] <= data, dirty <= 1.
//    addr == CMD_ADDR, data 4'h1: active <= shadow, dirty <= 0 (commit now).
//    addr == CMD_ADDR, data 4'h2: shadow <= RST_VALS, dirty <= 1 (defaults; a commit is still needed).
//    addr == CMD_ADDR, any other data: no-op, no error.
//    any other address: no register change, addr_err <= 1.
//    ack <= 1 for exactly this cycle -> WAIT_LOW.
//   WAIT_LOW: stay while valid=1; valid=0 -> IDLE. One level-held valid gives exactly one write.
//  Latency: valid rises at cycle N -> ack high in cycle N+2. Max throughput is one write per
//   4 cycles, provided valid drops in cycle N+3.
//  frame_start: when dirty=1, active <= shadow and dirty <= 0 on that clock.
//   frame_start with dirty=0 has no effect.
//  Simultaneous events, frame_start and APPLY in the same cycle:
//   commit uses the shadow value before the APPLY write.
//   dirty ends at 1 when APPLY wrote a register.
//   A command commit in APPLY wins and gives the same result.
//  addr_err clears only on rst.
//  rst mid-transaction: FSM returns to IDLE and the write is lost. If valid is still high after
//   reset release, it is treated as a new request.
//  cfg_active, dirty and addr_err come straight from flops; there is no combinational path from
//   the inputs.
// STRUCTURE
//  Shared package/header vga_cfg_defs: CMD_ADDR; command codes CMD_COMMIT=4'h1, CMD_DEFAULTS=4'h2;
//   register index names (REG_MODE=0, REG_FG_R/G/B=1..3, REG_BG_R/G/B=4..6, REG_PATTERN=7);
//   FSM state encodings.
//  One sub-module, cfg_shadow_regs: the shadow and active arrays plus the commit/default logic,
//   driven by wr_en/wr_addr/wr_data/commit/load_defaults strobes.
//  The top level holds the handshake FSM, address classification and addr_err.
// TESTING
//  1 Reset, then idle 10 cycles -> cfg_active == RST_VALS, ack=0, dirty=0, addr_err=0.
//  2 valid=1, addr=2, data=4'hA held 6 cycles -> exactly one ack 2 cycles after valid rises;
//    dirty=1; cfg_active reg2 unchanged until frame_start pulse, then reg2=4'hA and dirty=0.
//  3 Write reg5=4'h3, then CMD_ADDR data=4'h1 -> reg5 active=4'h3 right after the second ack,
//    with no frame_start.
//  4 Write addr=4'h9 data=4'h7 -> ack pulses, addr_err=1 and stays 1; all registers unchanged.
//  5 APPLY on reg1=4'hC in the same cycle as frame_start, with an earlier pending reg0=4'h5 ->
//    active reg0=5, reg1 old value, dirty=1; the next frame_start sets reg1=4'hC.
//  6 Assert rst in the cycle after valid rises (addr=3, data=4'hF) -> reg3 = default, no ack;
//    after release with valid still high -> one ack and the write is applied.

Source files
------------

// File: rtl/vga_cfg_defs_pkg.sv
// Shared definitions for the VGA configuration register bank: command
// address and codes, register index names and handshake FSM encodings.
package vga_cfg_defs;

    localparam logic [3:0] CMD_ADDR_DEFAULT = 4'hF;
    localparam logic [3:0] CMD_COMMIT       = 4'h1;
    localparam logic [3:0] CMD_DEFAULTS     = 4'h2;

    localparam int REG_MODE    = 0;
    localparam int REG_FG_R    = 1;
    localparam int REG_FG_G    = 2;
    localparam int REG_FG_B    = 3;
    localparam int REG_BG_R    = 4;
    localparam int REG_BG_G    = 5;
    localparam int REG_BG_B    = 6;
    localparam int REG_PATTERN = 7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_APPLY    = 2'd2,
        ST_WAIT_LOW = 2'd3
    } state_t;

endpackage

// File: rtl/cfg_shadow_regs.sv
// Shadow and active copies of the configuration registers. Writes and
// default loads land in the shadow copy; commit copies shadow to active.
// A commit in the same cycle as a shadow update uses the pre-update shadow.
module cfg_shadow_regs #(
    parameter int                           DATA_W   = 4,
    parameter int                           ADDR_W   = 4,
    parameter int                           NUM_REGS = 8,
    parameter logic [NUM_REGS*DATA_W-1:0]   RST_VALS = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        commit,
    input  logic                        load_defaults,
    output logic [NUM_REGS*DATA_W-1:0]  cfg_active,
    output logic                        dirty
);

    logic [NUM_REGS-1:0][DATA_W-1:0] shadow;
    logic [NUM_REGS-1:0][DATA_W-1:0] active;

    assign cfg_active = active;

    // Shadow/active update; dirty tracks whether a shadow change awaits commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= RST_VALS;
            active <= RST_VALS;
            dirty  <= 1'b0;
        end else begin
            if (commit) begin
                active <= shadow;
            end
            if (load_defaults) begin
                shadow <= RST_VALS;
            end else if (wr_en) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_addr == ADDR_W'(i)) begin
                        shadow[i] <= wr_data;
                    end
                end
            end
            if (wr_en || load_defaults) begin
                dirty <= 1'b1;
            end else if (commit) begin
                dirty <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/config_register_bank.sv
// VGA configuration register bank. A level-held valid from the address
// decoder produces exactly one write and one ack pulse. Register writes go
// to the shadow copy; the display-facing active copy only changes on a
// frame boundary or an explicit commit command.
module config_register_bank
    import vga_cfg_defs::*;
#(
    parameter int                           DATA_W   = 4,
    parameter int                           ADDR_W   = 4,
    parameter int                           NUM_REGS = 8,
    parameter logic [ADDR_W-1:0]            CMD_ADDR = ADDR_W'(CMD_ADDR_DEFAULT),
    parameter logic [NUM_REGS*DATA_W-1:0]   RST_VALS = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid,
    input  logic [ADDR_W-1:0]           address,
    input  logic [DATA_W-1:0]           data,
    input  logic                        frame_start,
    output logic                        ack,
    output logic [NUM_REGS*DATA_W-1:0]  cfg_active,
    output logic                        dirty,
    output logic                        addr_err
);

    state_t              state;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_data;
    logic                in_range;
    logic                is_cmd;
    logic                applying;
    logic                wr_en;
    logic                cmd_commit;
    logic                load_defaults;
    logic                commit;

    // Classify the captured request; strobes only fire during APPLY.
    always_comb begin
        in_range      = cap_addr < ADDR_W'(NUM_REGS);
        is_cmd        = cap_addr == CMD_ADDR;
        applying      = state == ST_APPLY;
        wr_en         = applying && in_range;
        cmd_commit    = applying && is_cmd && (cap_data == DATA_W'(CMD_COMMIT));
        load_defaults = applying && is_cmd && (cap_data == DATA_W'(CMD_DEFAULTS));
        commit        = cmd_commit || (frame_start && dirty);
    end

    // Handshake FSM with registered ack and sticky address error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cap_addr <= '0;
            cap_data <= '0;
            ack      <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    cap_addr <= address;
                    cap_data <= data;
                    ack      <= 1'b1;
                    state    <= ST_APPLY;
                end
                ST_APPLY: begin
                    if (!in_range && !is_cmd) begin
                        addr_err <= 1'b1;
                    end
                    state <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    cfg_shadow_regs #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RST_VALS (RST_VALS)
    ) u_regs (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (cap_addr),
        .wr_data       (cap_data),
        .commit        (commit),
        .load_defaults (load_defaults),
        .cfg_active    (cfg_active),
        .dirty         (dirty)
    );

endmodule

// File: tb/tb_config_register_bank.sv
// Directed bench for config_register_bank. Defaults are non-zero
// (reg i = i+1) so reset and default-load behaviour is observable.
module tb_config_register_bank;

    localparam logic [31:0] RV = 32'h8765_4321;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  address = 4'h0;
    logic [3:0]  data = 4'h0;
    logic        frame_start = 1'b0;
    logic        ack;
    logic [31:0] cfg_active;
    logic        dirty;
    logic        addr_err;

    logic [31:0] exp_act;
    int          n_checks = 0;
    int          n_fail = 0;

    config_register_bank #(
        .DATA_W   (4),
        .ADDR_W   (4),
        .NUM_REGS (8),
        .CMD_ADDR (4'hF),
        .RST_VALS (RV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .address     (address),
        .data        (data),
        .frame_start (frame_start),
        .ack         (ack),
        .cfg_active  (cfg_active),
        .dirty       (dirty),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds valid for 'hold' cycles, then drops it and lets the FSM return to IDLE.
    task automatic do_write(input logic [3:0] a, input logic [3:0] d, input int hold,
                            output int acks, output int pos);
        acks = 0;
        pos  = -1;
        address = a;
        data    = d;
        valid   = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            tick();
            if (ack === 1'b1) begin
                acks++;
                pos = i;
            end
        end
        valid = 1'b0;
        tick();
        if (ack === 1'b1) acks++;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        #2 rst = 1'b0;
        exp_act = RV;
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (cfg_active !== exp_act) begin
            $display("FAIL reset_cfg: got %h expected %h", cfg_active, exp_act); n_fail++;
        end
        n_checks++;
        if ({ack, dirty, addr_err} !== 3'b000) begin
            $display("FAIL reset_flags: got ack/dirty/err %b expected 000", {ack, dirty, addr_err}); n_fail++;
        end
    endtask

    task automatic test_frame_commit();
        int acks, pos;
        do_write(4'h2, 4'hA, 6, acks, pos);
        n_checks++;
        if (acks !== 1 || pos !== 2) begin
            $display("FAIL single_ack: got %0d acks at %0d expected 1 at 2", acks, pos); n_fail++;
        end
        n_checks++;
        if (dirty !== 1'b1 || cfg_active !== exp_act) begin
            $display("FAIL pending_write: got dirty %b cfg %h expected 1 %h", dirty, cfg_active, exp_act); n_fail++;
        end
        pulse_frame();
        exp_act[8 +: 4] = 4'hA;
        n_checks++;
        if (dirty !== 1'b0 || cfg_active !== exp_act) begin
            $display("FAIL frame_commit: got dirty %b cfg %h expected 0 %h", dirty, cfg_active, exp_act); n_fail++;
        end
        pulse_frame();
        n_checks++;
        if (cfg_active !== exp_act) begin
            $display("FAIL idle_frame: got %h expected %h", cfg_active, exp_act); n_fail++;
        end
    endtask

    task automatic test_cmd_commit();
        int acks, pos;
        do_write(4'h5, 4'h3, 3, acks, pos);
        do_write(4'hF, 4'h1, 3, acks, pos);
        exp_act[20 +: 4] = 4'h3;
        n_checks++;
        if (acks !== 1 || dirty !== 1'b0 || cfg_active !== exp_act) begin
            $display("FAIL cmd_commit: got acks %0d dirty %b cfg %h expected 1 0 %h", acks, dirty, cfg_active, exp_act); n_fail++;
        end
    endtask

    task automatic test_cmd_noop();
        int acks, pos;
        do_write(4'hF, 4'h7, 3, acks, pos);
        n_checks++;
        if (acks !== 1 || dirty !== 1'b0 || addr_err !== 1'b0 || cfg_active !== exp_act) begin
            $display("FAIL cmd_noop: got acks %0d dirty %b err %b cfg %h expected 1 0 0 %h",
                     acks, dirty, addr_err, cfg_active, exp_act); n_fail++;
        end
    endtask

    task automatic test_defaults();
        int acks, pos;
        do_write(4'h7, 4'h9, 3, acks, pos);
        do_write(4'hF, 4'h2, 3, acks, pos);
        n_checks++;
        if (dirty !== 1'b1 || cfg_active !== exp_act) begin
            $display("FAIL defaults_pending: got dirty %b cfg %h expected 1 %h", dirty, cfg_active, exp_act); n_fail++;
        end
        pulse_frame();
        exp_act = RV;
        n_checks++;
        if (dirty !== 1'b0 || cfg_active !== exp_act) begin
            $display("FAIL defaults_commit: got dirty %b cfg %h expected 0 %h", dirty, cfg_active, exp_act); n_fail++;
        end
    endtask

    task automatic test_addr_err();
        int acks, pos;
        do_write(4'h9, 4'h7, 3, acks, pos);
        n_checks++;
        if (acks !== 1 || addr_err !== 1'b1 || dirty !== 1'b0 || cfg_active !== exp_act) begin
            $display("FAIL addr_err: got acks %0d err %b dirty %b cfg %h expected 1 1 0 %h",
                     acks, addr_err, dirty, cfg_active, exp_act); n_fail++;
        end
        do_write(4'h1, 4'h4, 3, acks, pos);
        pulse_frame();
        exp_act[4 +: 4] = 4'h4;
        n_checks++;
        if (addr_err !== 1'b1 || cfg_active !== exp_act) begin
            $display("FAIL addr_err_sticky: got err %b cfg %h expected 1 %h", addr_err, cfg_active, exp_act); n_fail++;
        end
    endtask

    task automatic test_simultaneous();
        int acks, pos;
        logic [3:0] old_r1;
        old_r1 = exp_act[4 +: 4];
        do_write(4'h0, 4'h5, 3, acks, pos);
        address = 4'h1;
        data    = 4'hC;
        valid   = 1'b1;
        tick();
        tick();
        n_checks++;
        if (ack !== 1'b1) begin
            $display("FAIL sim_ack: got %b expected 1", ack); n_fail++;
        end
        pulse_frame();
        valid = 1'b0;
        tick();
        exp_act[0 +: 4] = 4'h5;
        n_checks++;
        if (dirty !== 1'b1 || cfg_active !== exp_act || cfg_active[4 +: 4] !== old_r1) begin
            $display("FAIL sim_commit: got dirty %b cfg %h expected 1 %h", dirty, cfg_active, exp_act); n_fail++;
        end
        pulse_frame();
        exp_act[4 +: 4] = 4'hC;
        n_checks++;
        if (dirty !== 1'b0 || cfg_active !== exp_act) begin
            $display("FAIL sim_next_frame: got dirty %b cfg %h expected 0 %h", dirty, cfg_active, exp_act); n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int pos_a, pos_b;
        pos_a = -1;
        pos_b = -1;
        address = 4'h6;
        data    = 4'h1;
        valid   = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (ack === 1'b1) begin
                if (pos_a < 0) pos_a = i;
                else pos_b = i;
            end
            if (i == 3) valid = 1'b0;
            if (i == 4) begin
                address = 4'h7;
                data    = 4'hE;
                valid   = 1'b1;
            end
            if (i == 7) valid = 1'b0;
        end
        n_checks++;
        if (pos_a !== 2 || pos_b !== 6) begin
            $display("FAIL back_to_back_ack: got %0d,%0d expected 2,6", pos_a, pos_b); n_fail++;
        end
        pulse_frame();
        exp_act[24 +: 4] = 4'h1;
        exp_act[28 +: 4] = 4'hE;
        n_checks++;
        if (cfg_active !== exp_act) begin
            $display("FAIL back_to_back_data: got %h expected %h", cfg_active, exp_act); n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        int acks, pos;
        bit seen_ack;
        address = 4'h3;
        data    = 4'hF;
        valid   = 1'b1;
        tick();
        #2 rst = 1'b1;
        seen_ack = 1'b0;
        tick();
        if (ack === 1'b1) seen_ack = 1'b1;
        tick();
        if (ack === 1'b1) seen_ack = 1'b1;
        exp_act = RV;
        n_checks++;
        if (seen_ack || addr_err !== 1'b0 || dirty !== 1'b0 || cfg_active !== exp_act) begin
            $display("FAIL reset_mid: got ack %b err %b dirty %b cfg %h expected 0 0 0 %h",
                     seen_ack, addr_err, dirty, cfg_active, exp_act); n_fail++;
        end
        #2 rst = 1'b0;
        acks = 0;
        pos = -1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (ack === 1'b1) begin
                acks++;
                pos = i;
            end
        end
        valid = 1'b0;
        tick();
        n_checks++;
        if (acks !== 1 || pos !== 2 || dirty !== 1'b1) begin
            $display("FAIL reset_retry: got acks %0d at %0d dirty %b expected 1 at 2 dirty 1", acks, pos, dirty); n_fail++;
        end
        pulse_frame();
        exp_act[12 +: 4] = 4'hF;
        n_checks++;
        if (cfg_active !== exp_act) begin
            $display("FAIL reset_retry_data: got %h expected %h", cfg_active, exp_act); n_fail++;
        end
    endtask

    initial begin
        exp_act = RV;
        test_reset();
        test_frame_commit();
        test_cmd_commit();
        test_cmd_noop();
        test_defaults();
        test_addr_err();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
